// File: rtl/peak_detector.sv
`default_nettype none
// ============================================================================
// Module      : peak_detector
// Description : Streaming peak finder for an unsigned magnitude stream.
//               Tracks the running maximum while the peak_stb_in gate is high.
//               A maximum is declared a peak when it survives NRX_TRIG further
//               accepted, non-exceeding samples, or when the gate drops or the
//               packet ends. Each peak produces a one-cycle peak_stb_out and a
//               single-beat AXI-Stream trigger token (out_tvalid/out_tlast).
// Ports       : clk          - sole clock, rising edge
//               reset        - asynchronous reset, active low
//               clear        - synchronous soft clear, active high
//               in_tdata     - sample magnitude (DATA_WIDTH, unsigned)
//               in_tvalid    - sample valid
//               in_tready    - sample accept (low only while a token is pending)
//               in_tlast     - last sample of packet
//               peak_stb_in  - gate, sampled with each accepted beat
//               peak_stb_out - one-cycle peak strobe
//               out_tvalid   - trigger token valid
//               out_tlast    - mirrors out_tvalid (single-beat packet)
//               out_tready   - trigger token accept
// Revision    : 1.0 - initial release
// ============================================================================
module peak_detector #(
  parameter int DATA_WIDTH = 16,
  parameter int NRX_TRIG   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic                  in_tlast,
  input  logic                  peak_stb_in,
  output logic                  peak_stb_out,
  output logic                  out_tvalid,
  output logic                  out_tlast,
  input  logic                  out_tready
);

  localparam int              CNT_W = $clog2(NRX_TRIG + 1);
  localparam logic [CNT_W-1:0] NRX_C = CNT_W'(NRX_TRIG);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    EMIT     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   max_val;
  logic [CNT_W-1:0]        run_cnt;
  logic                    last_gate;   // gate of the confirming beat

  logic                    accept;
  logic                    exceed;
  logic [CNT_W-1:0]        run_next;

  assign accept   = in_tvalid && in_tready;
  assign exceed   = in_tdata > max_val;
  // Saturating increment; the count never wraps past NRX_TRIG.
  assign run_next = (run_cnt == NRX_C) ? run_cnt : run_cnt + CNT_W'(1);

  assign out_tlast = out_tvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      max_val      <= '0;
      run_cnt      <= '0;
      last_gate    <= 1'b0;
      peak_stb_out <= 1'b0;
      out_tvalid   <= 1'b0;
      in_tready    <= 1'b1;
    end else if (clear) begin
      state        <= IDLE;
      max_val      <= '0;
      run_cnt      <= '0;
      last_gate    <= 1'b0;
      peak_stb_out <= 1'b0;
      out_tvalid   <= 1'b0;
      in_tready    <= 1'b1;
    end else begin
      peak_stb_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && peak_stb_in) begin
            max_val <= in_tdata;
            run_cnt <= '0;
            state   <= TRACK;
          end
        end

        TRACK: begin
          if (accept) begin
            if (!peak_stb_in || in_tlast) begin
              // Gate drop or end of packet: confirm now. A larger sample
              // arriving on a gated tlast beat is stored first.
              if (peak_stb_in && exceed) begin
                max_val <= in_tdata;
              end
              state        <= EMIT;
              peak_stb_out <= 1'b1;
              out_tvalid   <= 1'b1;
              in_tready    <= 1'b0;
              last_gate    <= peak_stb_in;
            end else if (exceed) begin
              max_val <= in_tdata;
              run_cnt <= '0;
            end else begin
              run_cnt <= run_next;
              if (run_next == NRX_C) begin
                state        <= EMIT;
                peak_stb_out <= 1'b1;
                out_tvalid   <= 1'b1;
                in_tready    <= 1'b0;
                last_gate    <= 1'b1;
              end
            end
          end
        end

        EMIT: begin
          if (out_tready) begin
            out_tvalid <= 1'b0;
            in_tready  <= 1'b1;
            if (last_gate) begin
              // Still inside the gated region: suppress further peaks.
              state <= WAIT_LOW;
            end else begin
              state   <= IDLE;
              max_val <= '0;
              run_cnt <= '0;
            end
          end
        end

        WAIT_LOW: begin
          if (accept && (!peak_stb_in || in_tlast)) begin
            state   <= IDLE;
            max_val <= '0;
            run_cnt <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peak_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_peak_detector
// Description : Self-checking bench for peak_detector. Two instances
//               (NRX_TRIG=4 and NRX_TRIG=16) are driven one at a time; a
//               sequence-level reference model predicts which beats confirm
//               peaks and with what maximum.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_peak_detector;

  logic             clk;
  logic             reset;
  logic             clear;
  logic [1:0][15:0] tdata;
  logic [1:0]       tvalid;
  logic [1:0]       tready;
  logic [1:0]       tlast;
  logic [1:0]       gate;
  logic [1:0]       stb;
  logic [1:0]       otvalid;
  logic [1:0]       otlast;
  logic [1:0]       otready;
  logic [1:0][15:0] mx;

  int checks;
  int errors;
  int sel;

  // Monitor records
  int   acc_cnt [2];
  int   stb_cyc [2];
  int   hs      [2];
  int   viol    [2];
  logic [1:0] pv, pr, ps;
  int   cq_idx [$];
  int   cq_max [$];

  // Stimulus vector and model results
  logic [15:0] vd [$];
  logic        vg [$];
  logic        vl [$];
  int          eidx [$];
  int          emax [$];

  peak_detector #(.DATA_WIDTH(16), .NRX_TRIG(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_tdata(tdata[0]), .in_tvalid(tvalid[0]), .in_tready(tready[0]),
    .in_tlast(tlast[0]), .peak_stb_in(gate[0]), .peak_stb_out(stb[0]),
    .out_tvalid(otvalid[0]), .out_tlast(otlast[0]), .out_tready(otready[0])
  );

  peak_detector #(.DATA_WIDTH(16), .NRX_TRIG(16)) dut16 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_tdata(tdata[1]), .in_tvalid(tvalid[1]), .in_tready(tready[1]),
    .in_tlast(tlast[1]), .peak_stb_in(gate[1]), .peak_stb_out(stb[1]),
    .out_tvalid(otvalid[1]), .out_tlast(otlast[1]), .out_tready(otready[1])
  );

  assign mx[0] = dut4.max_val;
  assign mx[1] = dut16.max_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe both instances mid-cycle: protocol invariants, strobes, beats.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        pv[k] = 1'b0;
        pr[k] = 1'b0;
        ps[k] = 1'b0;
      end else begin
        if (pv[k] && !pr[k] && !otvalid[k]) viol[k]++;
        if (otlast[k] !== otvalid[k]) viol[k]++;
        if (tready[k] !== !otvalid[k]) viol[k]++;
        if (stb[k] && !otvalid[k]) viol[k]++;
        if (stb[k]) stb_cyc[k]++;
        if (stb[k] && !ps[k] && k == sel) begin
          cq_idx.push_back(acc_cnt[k] - 1);
          cq_max.push_back(int'(mx[k]));
        end
        if (otvalid[k] && otready[k]) hs[k]++;
        if (tvalid[k] && tready[k]) acc_cnt[k]++;
        pv[k] = otvalid[k];
        pr[k] = otready[k];
        ps[k] = stb[k];
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vclear();
    vd.delete(); vg.delete(); vl.delete();
  endtask

  task automatic add(input int d, input bit g, input bit l);
    vd.push_back(16'(d));
    vg.push_back(g);
    vl.push_back(l);
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input int k, input logic [15:0] d, input logic g,
                           input logic l, output bit ok);
    tdata[k]  = d;
    gate[k]   = g;
    tlast[k]  = l;
    tvalid[k] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (tready[k]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    tvalid[k] = 1'b0;
  endtask

  // Reference model: walk the beat list region by region. A gated region
  // starts on a gate-high beat; its peak is confirmed when the maximum has
  // been followed by nrx non-exceeding beats, or on the first beat that has
  // the gate low or tlast set. After a confirmation that leaves the gate
  // high, the rest of the region up to and including its closing beat
  // produces nothing.
  task automatic model_run(input int nrx);
    int i, n, run, conf, mv;
    eidx.delete();
    emax.delete();
    n = vd.size();
    i = 0;
    while (i < n) begin
      if (!vg[i]) begin
        i++;
        continue;
      end
      mv = int'(vd[i]);
      run = 0;
      conf = -1;
      for (int j = i + 1; j < n; j++) begin
        if (!vg[j] || vl[j]) begin
          if (vg[j] && int'(vd[j]) > mv) mv = int'(vd[j]);
          conf = j;
          break;
        end
        if (int'(vd[j]) > mv) begin
          mv = int'(vd[j]);
          run = 0;
        end else begin
          run++;
          if (run >= nrx) begin
            conf = j;
            break;
          end
        end
      end
      if (conf < 0) break;
      eidx.push_back(conf);
      emax.push_back(mv);
      i = conf + 1;
      if (vg[conf]) begin
        while (i < n && vg[i] && !vl[i]) i++;
        i++;
      end
    end
  endtask

  // Drive the current vector into instance k and compare against the model.
  task automatic run_vec(input int k, input int gap, input string name);
    int base_acc, base_n, base_cyc, base_hs, got_n, nrx;
    bit ok;
    sel = k;
    nrx = (k == 0) ? 4 : 16;
    model_run(nrx);
    base_acc = acc_cnt[k];
    base_n   = cq_idx.size();
    base_cyc = stb_cyc[k];
    base_hs  = hs[k];
    for (int i = 0; i < vd.size(); i++) begin
      cyc(gap);
      send_beat(k, vd[i], vg[i], vl[i], ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL %s accept_timeout: beat %0d not accepted within 200 cycles", name, i);
      end
    end
    cyc(8);
    got_n = cq_idx.size() - base_n;
    checks++;
    if (got_n !== eidx.size()) begin
      errors++;
      $display("FAIL %s strobe_count: got %0d expected %0d", name, got_n, eidx.size());
    end
    for (int j = 0; j < got_n && j < eidx.size(); j++) begin
      checks++;
      if (cq_idx[base_n+j] - base_acc !== eidx[j]) begin
        errors++;
        $display("FAIL %s peak%0d_beat: got %0d expected %0d", name, j,
                 cq_idx[base_n+j] - base_acc, eidx[j]);
      end
      checks++;
      if (cq_max[base_n+j] !== emax[j]) begin
        errors++;
        $display("FAIL %s peak%0d_max: got %0d expected %0d", name, j,
                 cq_max[base_n+j], emax[j]);
      end
    end
    checks++;
    if (stb_cyc[k] - base_cyc !== eidx.size()) begin
      errors++;
      $display("FAIL %s strobe_cycles: got %0d expected %0d", name,
               stb_cyc[k] - base_cyc, eidx.size());
    end
    checks++;
    if (hs[k] - base_hs !== eidx.size()) begin
      errors++;
      $display("FAIL %s token_handshakes: got %0d expected %0d", name,
               hs[k] - base_hs, eidx.size());
    end
    checks++;
    if (acc_cnt[k] - base_acc !== vd.size()) begin
      errors++;
      $display("FAIL %s beats_accepted: got %0d expected %0d", name,
               acc_cnt[k] - base_acc, vd.size());
    end
    checks++;
    if (viol[k] !== 0) begin
      errors++;
      $display("FAIL %s protocol_violations: got %0d expected 0", name, viol[k]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stb[k] !== 1'b0) begin errors++; $display("FAIL reset_stb%0d: got %b expected 0", k, stb[k]); end
      checks++;
      if (otvalid[k] !== 1'b0) begin errors++; $display("FAIL reset_tvalid%0d: got %b expected 0", k, otvalid[k]); end
      checks++;
      if (otlast[k] !== 1'b0) begin errors++; $display("FAIL reset_tlast%0d: got %b expected 0", k, otlast[k]); end
      checks++;
      if (tready[k] !== 1'b1) begin errors++; $display("FAIL reset_tready%0d: got %b expected 1", k, tready[k]); end
      checks++;
      if (mx[k] !== 16'd0) begin errors++; $display("FAIL reset_max%0d: got %0d expected 0", k, mx[k]); end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(5);
    checks++;
    if (stb_cyc[0] + stb_cyc[1] + hs[0] + hs[1] !== 0) begin
      errors++;
      $display("FAIL reset_idle_strobes: got %0d expected 0",
               stb_cyc[0] + stb_cyc[1] + hs[0] + hs[1]);
    end
  endtask

  task automatic test_basic();
    vclear();
    add(10,1,0); add(30,1,0); add(50,1,0); add(40,1,0);
    add(40,1,0); add(20,1,0); add(10,1,0); add(0,0,0);
    run_vec(0, 0, "basic");
  endtask

  task automatic test_gate_drop();
    vclear();
    add(5,1,0); add(9,1,0); add(7,1,0); add(3,0,0);
    add(4,1,0); add(1,0,0);
    run_vec(1, 0, "gate_drop");
  endtask

  task automatic test_one_peak();
    vclear();
    for (int i = 1; i <= 20; i++) add(i, 1, 0);
    for (int i = 0; i < 20; i++) add(20, 1, 0);
    add(0,0,0); add(7,1,0); add(7,1,0); add(0,0,0);
    run_vec(1, 0, "one_peak");
  endtask

  task automatic test_tlast();
    vclear();
    add(5,1,0); add(8,1,0); add(12,1,1); add(30,1,0);
    add(1,1,1); add(6,1,0); add(0,0,0);
    run_vec(1, 1, "tlast");
  endtask

  task automatic test_backpressure();
    int held;
    bit seen;
    vclear();
    add(5,1,0); add(1,1,0); add(1,1,0); add(1,1,0); add(1,1,0);
    add(9,0,0); add(4,1,0); add(4,1,0); add(0,0,0);
    otready[0] = 1'b0;
    held = 0;
    seen = 1'b0;
    fork
      run_vec(0, 0, "backpressure");
      begin
        for (int t = 0; t < 300; t++) begin
          @(negedge clk);
          if (stb[0]) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          for (int t = 0; t < 6; t++) begin
            if (t > 0) @(negedge clk);
            if (otvalid[0] && !tready[0]) held++;
          end
        end
        @(posedge clk);
        #1;
        otready[0] = 1'b1;
      end
    join
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL backpressure_strobe_timeout: got none expected 1 strobe");
    end
    checks++;
    if (held !== 6) begin
      errors++;
      $display("FAIL backpressure_hold: got %0d cycles expected 6", held);
    end
  endtask

  task automatic test_clear();
    bit ok;
    int base_n, base_cyc;
    sel = 0;
    base_n   = cq_idx.size();
    base_cyc = stb_cyc[0];
    send_beat(0, 16'd10, 1'b1, 1'b0, ok);
    send_beat(0, 16'd20, 1'b1, 1'b0, ok);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    checks++;
    if (mx[0] !== 16'd0) begin
      errors++;
      $display("FAIL clear_max: got %0d expected 0", mx[0]);
    end
    send_beat(0, 16'd7, 1'b0, 1'b0, ok);
    cyc(4);
    checks++;
    if (stb_cyc[0] - base_cyc !== 0 || cq_idx.size() !== base_n) begin
      errors++;
      $display("FAIL clear_no_strobe: got %0d expected 0", stb_cyc[0] - base_cyc);
    end
    vclear();
    for (int i = 0; i < 5; i++) add(3, 1, 0);
    add(0,0,0);
    run_vec(0, 0, "after_clear");
  endtask

  task automatic test_sparse_random();
    int d;
    vclear();
    for (int i = 0; i < 1023; i++) begin
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1000));
      add(d, d > 0, 0);
    end
    add(0,0,0);
    run_vec(0, 3, "sparse");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel    = 0;
    reset  = 1'b0;
    clear  = 1'b0;
    tdata  = '0;
    tvalid = '0;
    tlast  = '0;
    gate   = '0;
    otready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      acc_cnt[k] = 0; stb_cyc[k] = 0; hs[k] = 0; viol[k] = 0;
    end
    test_reset();
    test_basic();
    test_gate_drop();
    test_one_peak();
    test_tlast();
    test_backpressure();
    test_clear();
    test_sparse_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/peak_detector.md
# peak_detector

Streaming peak finder for sampled magnitude data. It tracks the maximum of an unsigned sample stream while an external gate (`peak_stb_in`) is high. A maximum is declared a peak once it survives `NRX_TRIG` further accepted samples without being exceeded. Each confirmed peak produces a one-cycle `peak_stb_out` strobe and a single-beat AXI-Stream trigger token, which the downstream RX trigger logic consumes.

## Interface
- `DATA_WIDTH`, 16: sample width, unsigned.
- `NRX_TRIG`, 16: number of consecutive accepted non-exceeding samples that confirm a peak; legal range ≥1.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous, active-high soft clear; same effect as reset.
- `in_tdata`  in  DATA_WIDTH  sample magnitude.
- `in_tvalid`  in  1  sample valid.
- `in_tready`  out  1  sample accept.
- `in_tlast`  in  1  last sample of packet.
- `peak_stb_in`  in  1  gate; sample eligible when high, sampled with each accepted beat.
- `peak_stb_out`  out  1  one-cycle peak strobe.
- `out_tvalid`  out  1  trigger token valid.
- `out_tlast`  out  1  always equal to `out_tvalid` (single-beat packet).
- `out_tready`  in  1  trigger token accept.

## Operation
- An accepted beat is one where `in_tvalid && in_tready` on a rising edge. Only accepted beats advance state.
- Registers:
  - `max_val` [DATA_WIDTH]
  - `run_cnt` [$clog2(NRX_TRIG+1)]
  - FSM
- State IDLE (`max_val`=0, `run_cnt`=0):
  - On an accepted beat with gate=1: `max_val` ← `in_tdata`, `run_cnt` ← 0, go to TRACK.
- State TRACK, on an accepted beat:
  - If gate=1 and `in_tdata` > `max_val` (strict, unsigned): `max_val` ← `in_tdata`, `run_cnt` ← 0.
  - If gate=1 and not exceeding: `run_cnt` ← `run_cnt`+1. Reaching `NRX_TRIG` confirms the peak.
  - If gate=0, or `in_tlast`=1: the peak is confirmed immediately with the current `max_val`. An equal sample does not replace the stored value.
  - On confirmation, go to EMIT.
- State EMIT:
  - `out_tvalid` is held high until `out_tready`.
  - After the handshake, go to WAIT_LOW if the last accepted gate was 1; otherwise go to IDLE.
- State WAIT_LOW:
  - Accepted beats with gate=1 are ignored (one peak per gated region).
  - The first accepted beat with gate=0, or with `in_tlast`, returns the FSM to IDLE.
- `in_tready` = 1 in all states except EMIT. Samples are back-pressured, never dropped.
- No data output; the peak value is internal. `max_val` is held until IDLE re-entry.

## Timing
- Reset / clear values: FSM=IDLE, `max_val`=0, `run_cnt`=0, `peak_stb_out`=0, `out_tvalid`=0, `out_tlast`=0, `in_tready`=1.
- `peak_stb_out` is registered. It is high for exactly the one cycle following the edge on which the confirming beat was accepted.
- `out_tvalid` rises in the same cycle as `peak_stb_out`.
- Trigger latency: 1 clock from the confirming beat.
- With `out_tready`=1, `out_tvalid` is high for 1 cycle and `in_tready` is low for 1 cycle.
- `out_tvalid` must not drop without a handshake. `out_tlast` mirrors it.
- `run_cnt` saturates at `NRX_TRIG`; it never wraps.
- Simultaneous events:
  - A new max and `in_tlast` on the same beat: the new max is stored, then confirmed.
  - Gate=0 on the first beat while in IDLE: stay in IDLE.
- `clear` has priority over all other synchronous activity.
- Asserting `reset` mid-EMIT drops `out_tvalid` immediately (asynchronous). This is the only legal valid-drop.
- Sparse input (valid every N cycles) is fully supported; idle cycles change nothing.

## Test plan
- Reset: hold `reset`=0 for 5 cycles → all outputs at reset values, `in_tready`=1. Release → no strobe with `in_tvalid`=0.
- Basic peak, `NRX_TRIG`=4, gate=1, beats 10, 30, 50, 40, 40, 20, 10 → exactly one `peak_stb_out` one cycle after beat 10 (the 4th non-exceeding beat); internal `max_val`=50; one `out_tvalid` beat with `out_tlast`=1.
- Gate drop: `NRX_TRIG`=16, gate=1 for 5, 9, 7, then gate=0 on next beat → peak confirmed on the gate-0 beat with `max_val`=9; FSM then returns to IDLE (not WAIT_LOW).
- One peak per region: gate held 1 for 40 beats of a ramp 1..20 then flat 20 with `NRX_TRIG`=16 → single strobe; no further strobe until gate goes 0 and back to 1.
- Back-pressure: `out_tready`=0 for 6 cycles at confirmation → `out_tvalid` held 6+ cycles, `in_tready`=0 throughout, `peak_stb_out` still one cycle; no input beats lost.
- Sparse stream: `in_tvalid` every 4th cycle, `out_tready`=1, 1024-sample vector with gate = (`in_tdata`>0) → strobe count equals the number of gated regions whose max survives or ends; `clear` pulse mid-TRACK returns to IDLE with no strobe.
